// File: rtl/frame_sync_pkg.sv
// Shared types and default parameters for the serial frame synchroniser.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PAYLOAD  = 2'd1,
    SYNC_CHK = 2'd2
  } state_e;

  localparam logic [3:0]  DEF_SYNC_PAT      = 4'b1011;
  localparam int unsigned DEF_PAYLOAD_BYTES = 2;
  localparam int unsigned DEF_LOCK_COUNT    = 2;
  localparam int unsigned DEF_MISS_LIMIT    = 2;

endpackage

// File: rtl/frame_byte_buf.sv
// One-entry output holding register: loads completed bytes, drops them with an
// overflow pulse when the previous byte is still waiting for the consumer.
module frame_byte_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;
  logic       handshake;

  assign handshake = valid_q & ready;

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    if (load) begin
      // A byte arriving during a handshake replaces the departing one.
      if (!valid_q || handshake) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Serial frame synchroniser: hunts for the sync word, tracks lock with a
// flywheel, and offers payload bytes through a one-entry holding register.
module frame_sync_ctrl
  import frame_sync_pkg::*;
#(
  parameter logic [3:0]  SYNC_PAT      = DEF_SYNC_PAT,
  parameter int unsigned PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
  parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int unsigned MISS_LIMIT    = DEF_MISS_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic       overflow
);

  localparam logic [6:0] LastBit = 7'(PAYLOAD_BYTES * 8 - 1);
  localparam logic [2:0] LockCnt = 3'(LOCK_COUNT);
  localparam logic [2:0] MissLim = 3'(MISS_LIMIT);

  state_e     state_q, state_d;
  // Only the three older sync bits are stored; the fourth is the live in_bit.
  logic [2:0] sync_hist_q, sync_hist_d;
  logic [6:0] byte_sh_q, byte_sh_d;
  logic [6:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] good_cnt_q, good_cnt_d;
  logic [2:0] miss_cnt_q, miss_cnt_d;
  logic       locked_q, locked_d;
  logic       frame_start_q, frame_start_d;
  logic       sync_err_q, sync_err_d;
  logic       byte_done;
  logic [3:0] sync_word;

  assign sync_word = {sync_hist_q, in_bit};

  always_comb begin
    state_d       = state_q;
    sync_hist_d   = sync_hist_q;
    byte_sh_d     = byte_sh_q;
    bit_cnt_d     = bit_cnt_q;
    good_cnt_d    = good_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    locked_d      = locked_q | (good_cnt_q >= LockCnt);
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    byte_done     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          sync_hist_d = sync_word[2:0];
          if (bit_cnt_q < 7'd3) bit_cnt_d = bit_cnt_q + 7'd1;
          if (bit_cnt_q >= 7'd3 && sync_word == SYNC_PAT) begin
            state_d       = PAYLOAD;
            bit_cnt_d     = 7'd0;
            byte_sh_d     = 7'd0;
            frame_start_d = 1'b1;
            good_cnt_d    = 3'd1;
            miss_cnt_d    = 3'd0;
          end
        end
        PAYLOAD: begin
          byte_sh_d = {byte_sh_q[5:0], in_bit};
          byte_done = (bit_cnt_q[2:0] == 3'd7);
          if (bit_cnt_q == LastBit) begin
            state_d   = SYNC_CHK;
            bit_cnt_d = 7'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
        SYNC_CHK: begin
          sync_hist_d = sync_word[2:0];
          if (bit_cnt_q[1:0] == 2'd3) begin
            bit_cnt_d = 7'd0;
            if (sync_word == SYNC_PAT) begin
              state_d       = PAYLOAD;
              frame_start_d = 1'b1;
              miss_cnt_d    = 3'd0;
              if (good_cnt_q < LockCnt) good_cnt_d = good_cnt_q + 3'd1;
            end else if (miss_cnt_q + 3'd1 >= MissLim) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              sync_err_d  = 1'b1;
              good_cnt_d  = 3'd0;
              miss_cnt_d  = 3'd0;
              sync_hist_d = 3'd0;
              byte_sh_d   = 7'd0;
            end else begin
              // Flywheel: tolerate the miss and keep the frame timing.
              state_d    = PAYLOAD;
              good_cnt_d = 3'd0;
              miss_cnt_d = miss_cnt_q + 3'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      sync_hist_q   <= 3'd0;
      byte_sh_q     <= 7'd0;
      bit_cnt_q     <= 7'd0;
      good_cnt_q    <= 3'd0;
      miss_cnt_q    <= 3'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_hist_q   <= sync_hist_d;
      byte_sh_q     <= byte_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  frame_byte_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (byte_done & locked_q),
    .load_data ({byte_sh_q, in_bit}),
    .ready     (data_ready),
    .data      (data_out),
    .valid     (data_valid),
    .overflow  (overflow)
  );

  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl: lock acquisition, flywheel, overflow,
// sparse in_valid and mid-frame reset.
module tb_frame_sync_ctrl;
  import frame_sync_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       locked;
  logic       frame_start;
  logic       sync_err;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int gap   = 0;

  int         fs_cnt = 0;
  int         se_cnt = 0;
  int         of_cnt = 0;
  logic [7:0] rx_q[$];

  frame_sync_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .locked      (locked),
    .frame_start (frame_start),
    .sync_err    (sync_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after posedge, so negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) fs_cnt++;
      if (sync_err) se_cnt++;
      if (overflow) of_cnt++;
      if (data_valid && data_ready) rx_q.push_back(data_out);
    end
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_bit   = b;
    repeat (gap) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_nib(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    in_valid   = 1'b1;
    data_ready = 1'b1;
    repeat (2) begin
      in_bit = 1'($urandom);
      @(posedge clk); #1;
    end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data_out: got %h want 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_data_valid: got %b want 0", data_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL rst_sync_err: got %b want 0", sync_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (dut.state_q !== HUNT) begin n_bad++; $display("FAIL rst_state: got %0d want HUNT", dut.state_q); end
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_sync_lock(input int g);
    int fs0, se0, rx0;
    gap = g;
    do_reset();
    data_ready = 1'b1;
    fs0 = fs_cnt; se0 = se_cnt; rx0 = rx_q.size();
    send_nib(4'b1011); send_byte(8'hA5); send_byte(8'h3C);
    idle(2);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early g=%0d: got %b want 0", g, locked); end
    n_cmp++; if (fs_cnt - fs0 !== 1) begin n_bad++; $display("FAIL fs_first g=%0d: got %0d want 1", g, fs_cnt - fs0); end
    n_cmp++; if (rx_q.size() - rx0 !== 0) begin n_bad++; $display("FAIL unlocked_discard g=%0d: got %0d bytes want 0", g, rx_q.size() - rx0); end
    send_nib(4'b1011);
    idle(2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_second g=%0d: got %b want 1", g, locked); end
    n_cmp++; if (fs_cnt - fs0 !== 2) begin n_bad++; $display("FAIL fs_second g=%0d: got %0d want 2", g, fs_cnt - fs0); end
    send_byte(8'h5A); send_byte(8'hC3);
    idle(3);
    n_cmp++; if (rx_q.size() - rx0 !== 2) begin n_bad++; $display("FAIL rx_count g=%0d: got %0d want 2", g, rx_q.size() - rx0); end
    n_cmp++; if (rx_q[rx0] !== 8'h5A) begin n_bad++; $display("FAIL rx_byte0 g=%0d: got %h want 5A", g, rx_q[rx0]); end
    n_cmp++; if (rx_q[rx0+1] !== 8'hC3) begin n_bad++; $display("FAIL rx_byte1 g=%0d: got %h want C3", g, rx_q[rx0+1]); end
    n_cmp++; if (se_cnt - se0 !== 0) begin n_bad++; $display("FAIL no_sync_err g=%0d: got %0d want 0", g, se_cnt - se0); end
    n_cmp++; if (dut.state_q !== SYNC_CHK) begin n_bad++; $display("FAIL state_chk g=%0d: got %0d want SYNC_CHK", g, dut.state_q); end
    gap = 0;
  endtask

  // Continues from the locked SYNC_CHK state left by test_sync_lock.
  task automatic test_flywheel();
    int fs0, se0, rx0;
    fs0 = fs_cnt; se0 = se_cnt; rx0 = rx_q.size();
    send_nib(4'b1001); send_byte(8'h66); send_byte(8'h99);
    idle(3);
    n_cmp++; if (se_cnt - se0 !== 0) begin n_bad++; $display("FAIL fly_no_err: got %0d want 0", se_cnt - se0); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL fly_locked: got %b want 1", locked); end
    n_cmp++; if (fs_cnt - fs0 !== 0) begin n_bad++; $display("FAIL fly_no_fs: got %0d want 0", fs_cnt - fs0); end
    n_cmp++; if (rx_q.size() - rx0 !== 2) begin n_bad++; $display("FAIL fly_rx_count: got %0d want 2", rx_q.size() - rx0); end
    n_cmp++; if (rx_q[rx0] !== 8'h66) begin n_bad++; $display("FAIL fly_byte0: got %h want 66", rx_q[rx0]); end
    n_cmp++; if (rx_q[rx0+1] !== 8'h99) begin n_bad++; $display("FAIL fly_byte1: got %h want 99", rx_q[rx0+1]); end
    send_nib(4'b0000);
    idle(3);
    n_cmp++; if (se_cnt - se0 !== 1) begin n_bad++; $display("FAIL loss_sync_err: got %0d want 1", se_cnt - se0); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL loss_locked: got %b want 0", locked); end
    n_cmp++; if (dut.state_q !== HUNT) begin n_bad++; $display("FAIL loss_state: got %0d want HUNT", dut.state_q); end
  endtask

  task automatic test_overflow();
    int of0, rx0;
    do_reset();
    data_ready = 1'b1;
    send_nib(4'b1011); send_byte(8'h00); send_byte(8'h00); send_nib(4'b1011);
    of0 = of_cnt; rx0 = rx_q.size();
    data_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22);
    idle(2);
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b want 1", data_valid); end
    n_cmp++; if (data_out !== 8'h11) begin n_bad++; $display("FAIL ovf_hold: got %h want 11", data_out); end
    n_cmp++; if (of_cnt - of0 !== 1) begin n_bad++; $display("FAIL ovf_pulse: got %0d want 1", of_cnt - of0); end
    data_ready = 1'b1;
    idle(3);
    n_cmp++; if (rx_q.size() - rx0 !== 1) begin n_bad++; $display("FAIL ovf_rx_count: got %0d want 1", rx_q.size() - rx0); end
    n_cmp++; if (rx_q[rx0] !== 8'h11) begin n_bad++; $display("FAIL ovf_rx_byte: got %h want 11", rx_q[rx0]); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", data_valid); end
  endtask

  task automatic test_reset_mid();
    int fs0;
    do_reset();
    data_ready = 1'b1;
    send_nib(4'b1011); send_byte(8'h00); send_byte(8'h00); send_nib(4'b1011);
    data_ready = 1'b0;
    send_byte(8'hAA);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n_cmp++; if (data_valid !== 1'b1 || data_out !== 8'hAA) begin
      n_bad++; $display("FAIL mid_offered: got %b/%h want 1/AA", data_valid, data_out);
    end
    // Third payload bit is still pending with in_valid=1; reset must win.
    rst        = 1'b1;
    data_ready = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", data_valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL mid_data: got %h want 00", data_out); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mid_locked: got %b want 0", locked); end
    n_cmp++; if (dut.state_q !== HUNT) begin n_bad++; $display("FAIL mid_state: got %0d want HUNT", dut.state_q); end
    fs0 = fs_cnt;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    idle(2);
    n_cmp++; if (fs_cnt - fs0 !== 0) begin n_bad++; $display("FAIL mid_no_fs: got %0d want 0", fs_cnt - fs0); end
    send_nib(4'b1011);
    idle(2);
    n_cmp++; if (fs_cnt - fs0 !== 1) begin n_bad++; $display("FAIL mid_fresh_fs: got %0d want 1", fs_cnt - fs0); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mid_relock: got %b want 0", locked); end
  endtask

  initial begin
    rst        = 1'b1;
    in_bit     = 1'b0;
    in_valid   = 1'b0;
    data_ready = 1'b0;
    test_reset();
    test_sync_lock(0);
    test_flywheel();
    test_overflow();
    test_sync_lock(2);
    test_reset_mid();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
